// File: rtl/ym3438_reg_wr.sv
// ym3438_reg_wr: CPU-side register write port for the OPN2 core.
// Latches address/data bus writes, paces data writes with a busy flag that
// counts slot ticks, holds the global LFO registers and the per-channel
// FNUM/block/PMS/AMS/LR registers, and presents the per-channel values of
// the channel currently being scanned.
// Optional build macro: YM3438_WR_QUEUE_EN adds a one-entry queue that
// holds the first data write received while busy.
module ym3438_reg_wr #(
  parameter int unsigned BUSY_TICKS = 32
) (
  input  logic        MCLK,
  input  logic        IC,
  input  logic        slot_tick,
  input  logic        cpu_wr,
  input  logic        cpu_a0,
  input  logic        cpu_a1,
  input  logic [7:0]  cpu_data,
  output logic        busy,
  output logic [7:0]  reg_21,
  output logic [3:0]  lfo,
  output logic [2:0]  ch_idx,
  output logic [10:0] fnum,
  output logic [2:0]  block,
  output logic [2:0]  pms,
  output logic [1:0]  ams,
  output logic [1:0]  lr
);

  localparam logic [7:0] BUSY_LOAD = 8'(BUSY_TICKS);

  logic        addr_wr;
  logic        data_wr;

  logic [7:0]  addr_q;
  logic        bank_q;
  logic [5:0]  fnum_hi_q;

  logic [10:0] fnum_q  [6];
  logic [2:0]  block_q [6];
  logic [2:0]  pms_q   [6];
  logic [1:0]  ams_q   [6];
  logic [1:0]  lr_q    [6];

  logic [7:0]  reg21_q;
  logic [3:0]  lfo_q;
  logic [7:0]  busy_cnt_q, busy_cnt_d;
  logic [2:0]  ch_cnt_q, ch_cnt_d;

  logic [2:0]  ch_idx_q;
  logic [10:0] fnum_out_q;
  logic [2:0]  block_out_q;
  logic [2:0]  pms_out_q;
  logic [1:0]  ams_out_q;
  logic [1:0]  lr_out_q;

  // Selected commit (from the bus or from the queue)
  logic        wr_en;
  logic        wr_bank;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;

  // Decode results
  logic [1:0]  wr_c;
  logic        wr_ch_ok;
  logic [2:0]  wr_ch;
  logic        hit_21, hit_22, hit_hi, hit_fnum, hit_pan;

  assign addr_wr = cpu_wr & ~cpu_a0;
  assign data_wr = cpu_wr & cpu_a0;
  assign busy    = (busy_cnt_q != '0);

`ifdef YM3438_WR_QUEUE_EN
  logic        q_valid_q;
  logic        q_bank_q;
  logic [7:0]  q_addr_q;
  logic [7:0]  q_data_q;
  logic        q_cap;

  // Pick commit source: a held entry drains first once busy has fallen;
  // a bus write arriving in that same cycle is dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_bank = bank_q;
    wr_addr = addr_q;
    wr_data = cpu_data;
    q_cap   = 1'b0;
    if (!busy) begin
      if (q_valid_q) begin
        wr_en   = 1'b1;
        wr_bank = q_bank_q;
        wr_addr = q_addr_q;
        wr_data = q_data_q;
      end else if (data_wr) begin
        wr_en = 1'b1;
      end
    end else if (data_wr && !q_valid_q) begin
      q_cap = 1'b1;
    end
  end

  // One-entry queue: capture first write while busy, release on commit
  always_ff @(posedge MCLK) begin
    if (IC) begin
      q_valid_q <= 1'b0;
      q_bank_q  <= 1'b0;
      q_addr_q  <= '0;
      q_data_q  <= '0;
    end else if (q_cap) begin
      q_valid_q <= 1'b1;
      q_bank_q  <= bank_q;
      q_addr_q  <= addr_q;
      q_data_q  <= cpu_data;
    end else if (!busy && q_valid_q) begin
      q_valid_q <= 1'b0;
    end
  end
`else
  // Pick commit source: only bus writes, dropped while busy
  always_comb begin
    wr_en   = data_wr & ~busy;
    wr_bank = bank_q;
    wr_addr = addr_q;
    wr_data = cpu_data;
  end
`endif

  // Address decode of the committed write
  always_comb begin
    wr_c     = wr_addr[1:0];
    wr_ch_ok = (wr_c != 2'b11);
    wr_ch    = wr_bank ? (3'd3 + {1'b0, wr_c}) : {1'b0, wr_c};
    hit_21   = wr_en & ~wr_bank & (wr_addr == 8'h21);
    hit_22   = wr_en & ~wr_bank & (wr_addr == 8'h22);
    hit_hi   = wr_en & wr_ch_ok & (wr_addr[7:2] == 6'b1010_01);
    hit_fnum = wr_en & wr_ch_ok & (wr_addr[7:2] == 6'b1010_00);
    hit_pan  = wr_en & wr_ch_ok & (wr_addr[7:2] == 6'b1011_01);
  end

  // Busy counter and channel scan next state
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (slot_tick && busy) busy_cnt_d = busy_cnt_q - 8'd1;
    if (wr_en) busy_cnt_d = BUSY_LOAD;
    ch_cnt_d = ch_cnt_q;
    if (slot_tick) ch_cnt_d = (ch_cnt_q == 3'd5) ? 3'd0 : ch_cnt_q + 3'd1;
  end

  // Bus latches, global registers and counters
  always_ff @(posedge MCLK) begin
    if (IC) begin
      addr_q     <= '0;
      bank_q     <= 1'b0;
      fnum_hi_q  <= '0;
      reg21_q    <= '0;
      lfo_q      <= '0;
      busy_cnt_q <= '0;
      ch_cnt_q   <= '0;
    end else begin
      if (addr_wr) begin
        addr_q <= cpu_data;
        bank_q <= cpu_a1;
      end
      if (hit_21) reg21_q   <= wr_data;
      if (hit_22) lfo_q     <= wr_data[3:0];
      if (hit_hi) fnum_hi_q <= wr_data[5:0];
      busy_cnt_q <= busy_cnt_d;
      ch_cnt_q   <= ch_cnt_d;
    end
  end

  // Per-channel register arrays
  always_ff @(posedge MCLK) begin
    if (IC) begin
      for (int unsigned i = 0; i < 6; i++) begin
        fnum_q[i]  <= '0;
        block_q[i] <= '0;
        pms_q[i]   <= '0;
        ams_q[i]   <= '0;
        lr_q[i]    <= '1;
      end
    end else begin
      if (hit_fnum) begin
        fnum_q[wr_ch]  <= {fnum_hi_q[2:0], wr_data};
        block_q[wr_ch] <= fnum_hi_q[5:3];
      end
      if (hit_pan) begin
        lr_q[wr_ch]  <= wr_data[7:6];
        ams_q[wr_ch] <= wr_data[5:4];
        pms_q[wr_ch] <= wr_data[2:0];
      end
    end
  end

  // Registered presentation of the scanned channel
  always_ff @(posedge MCLK) begin
    if (IC) begin
      ch_idx_q    <= '0;
      fnum_out_q  <= '0;
      block_out_q <= '0;
      pms_out_q   <= '0;
      ams_out_q   <= '0;
      lr_out_q    <= '1;
    end else begin
      ch_idx_q    <= ch_cnt_q;
      fnum_out_q  <= fnum_q[ch_cnt_q];
      block_out_q <= block_q[ch_cnt_q];
      pms_out_q   <= pms_q[ch_cnt_q];
      ams_out_q   <= ams_q[ch_cnt_q];
      lr_out_q    <= lr_q[ch_cnt_q];
    end
  end

  assign reg_21 = reg21_q;
  assign lfo    = lfo_q;
  assign ch_idx = ch_idx_q;
  assign fnum   = fnum_out_q;
  assign block  = block_out_q;
  assign pms    = pms_out_q;
  assign ams    = ams_out_q;
  assign lr     = lr_out_q;

endmodule

// File: tb/tb_ym3438_reg_wr.sv
// Self-checking bench for ym3438_reg_wr: directed steps followed by random
// bus traffic, compared every cycle against a behavioural register model.
module tb_ym3438_reg_wr;

  localparam int BT = 32;

  logic        MCLK = 1'b0;
  logic        IC, slot_tick, cpu_wr, cpu_a0, cpu_a1;
  logic [7:0]  cpu_data;
  logic        busy;
  logic [7:0]  reg_21;
  logic [3:0]  lfo;
  logic [2:0]  ch_idx;
  logic [10:0] fnum;
  logic [2:0]  block, pms;
  logic [1:0]  ams, lr;

  always #5 MCLK = ~MCLK;

  ym3438_reg_wr #(.BUSY_TICKS(BT)) dut (
    .MCLK(MCLK), .IC(IC), .slot_tick(slot_tick), .cpu_wr(cpu_wr),
    .cpu_a0(cpu_a0), .cpu_a1(cpu_a1), .cpu_data(cpu_data), .busy(busy),
    .reg_21(reg_21), .lfo(lfo), .ch_idx(ch_idx), .fnum(fnum), .block(block),
    .pms(pms), .ams(ams), .lr(lr)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model
  typedef struct { logic bank; logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t pend[$];
  int m_reg21, m_lfo, m_addr, m_bank, m_hi, m_busy_left, m_ch;
  int m_fnum[6], m_block[6], m_pms[6], m_ams[6], m_lr[6];
  int e_busy, e_reg21, e_lfo, e_idx, e_fnum, e_block, e_pms, e_ams, e_lr;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_apply(input int b, input int a, input int d);
    int ch;
    if (b == 0 && a == 'h21) m_reg21 = d;
    if (b == 0 && a == 'h22) m_lfo = d % 16;
    if (a >= 'hA4 && a <= 'hA6) m_hi = d % 64;
    if (a >= 'hA0 && a <= 'hA2) begin
      ch = b * 3 + (a - 'hA0);
      m_fnum[ch]  = (m_hi % 8) * 256 + d;
      m_block[ch] = m_hi / 8;
    end
    if (a >= 'hB4 && a <= 'hB6) begin
      ch = b * 3 + (a - 'hB4);
      m_lr[ch]  = d / 64;
      m_ams[ch] = (d / 16) % 4;
      m_pms[ch] = d % 8;
    end
  endfunction

  function automatic void m_reset();
    m_reg21 = 0; m_lfo = 0; m_addr = 0; m_bank = 0; m_hi = 0;
    m_busy_left = 0; m_ch = 0;
    pend.delete();
    for (int i = 0; i < 6; i++) begin
      m_fnum[i] = 0; m_block[i] = 0; m_pms[i] = 0; m_ams[i] = 0; m_lr[i] = 3;
    end
    e_busy = 0; e_reg21 = 0; e_lfo = 0; e_idx = 0;
    e_fnum = 0; e_block = 0; e_pms = 0; e_ams = 0; e_lr = 3;
  endfunction

  function automatic void m_edge(input int tk, input int wr, input int a0,
                                 input int a1, input int d);
    int  busy_now;
    wr_t w;
    bit  commit;
    // presented values reflect the channel and contents before this edge
    e_idx = m_ch; e_fnum = m_fnum[m_ch]; e_block = m_block[m_ch];
    e_pms = m_pms[m_ch]; e_ams = m_ams[m_ch]; e_lr = m_lr[m_ch];
    busy_now = (m_busy_left > 0);
    commit = 0;
    if (!busy_now && pend.size() > 0) begin
      w = pend.pop_front();
      m_apply(w.bank, w.addr, w.data);
      commit = 1;
    end else if (wr && a0) begin
      if (!busy_now) begin
        m_apply(m_bank, m_addr, d);
        commit = 1;
      end else begin
`ifdef YM3438_WR_QUEUE_EN
        if (pend.size() == 0) begin
          w.bank = 1'(m_bank); w.addr = 8'(m_addr); w.data = 8'(d);
          pend.push_back(w);
        end
`endif
      end
    end
    if (commit) m_busy_left = BT;
    else if (tk && busy_now) m_busy_left--;
    if (wr && !a0) begin m_addr = d; m_bank = a1; end
    if (tk) m_ch = (m_ch + 1) % 6;
    e_busy = (m_busy_left > 0);
    e_reg21 = m_reg21; e_lfo = m_lfo;
  endfunction

  task automatic check_all();
    chk("busy",   16'(busy),   16'(e_busy));
    chk("reg_21", 16'(reg_21), 16'(e_reg21));
    chk("lfo",    16'(lfo),    16'(e_lfo));
    chk("ch_idx", 16'(ch_idx), 16'(e_idx));
    chk("fnum",   16'(fnum),   16'(e_fnum));
    chk("block",  16'(block),  16'(e_block));
    chk("pms",    16'(pms),    16'(e_pms));
    chk("ams",    16'(ams),    16'(e_ams));
    chk("lr",     16'(lr),     16'(e_lr));
  endtask

  // One MCLK cycle: drive, update model, clock, sample on the falling edge
  task automatic step(input logic ic, input logic tk, input logic wr,
                      input logic a0, input logic a1, input logic [7:0] d);
    IC = ic; slot_tick = tk; cpu_wr = wr; cpu_a0 = a0; cpu_a1 = a1; cpu_data = d;
    if (ic) m_reset();
    else m_edge(int'(tk), int'(wr), int'(a0), int'(a1), int'(d));
    @(posedge MCLK);
    @(negedge MCLK);
    IC = 1'b0; slot_tick = 1'b0; cpu_wr = 1'b0;
    check_all();
  endtask

  task automatic idle();            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); endtask
  task automatic tick();            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); endtask
  task automatic awr(input logic a1, input logic [7:0] a); step(1'b0, 1'b0, 1'b1, 1'b0, a1, a); endtask
  task automatic dwr(input logic [7:0] d); step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, d); endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy_left > 0 && n < 300) begin tick(); n++; end
    chk("wait_idle", 16'(busy), 16'd0);
  endtask

  task automatic goto_ch(input int c);
    int n = 0;
    while (e_idx != c && n < 14) begin tick(); idle(); n++; end
    chk("goto_ch", 16'(ch_idx), 16'(c));
  endtask

  logic [7:0] pool [16];

  initial begin
    int n, seq, r;
    pool = '{8'h21, 8'h22, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5,
             8'hA6, 8'hA7, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'h28, 8'h30};
    IC = 1'b1; slot_tick = 1'b0; cpu_wr = 1'b0; cpu_a0 = 1'b0; cpu_a1 = 1'b0; cpu_data = '0;
    @(negedge MCLK);
    // reset, with a concurrent write and tick that must be overridden
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_ch", 16'(ch_idx), 16'd0);
    chk("rst_lfo", 16'(lfo), 16'd0);
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("rst_lr", 16'(lr), 16'd3);
      tick();
    end

    // LFO write and busy duration
    awr(1'b0, 8'h22); dwr(8'h0B);
    chk("lfo_b", 16'(lfo), 16'hB);
    chk("busy_set", 16'(busy), 16'd1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin tick(); n++; end
    chk("busy_len", 16'(n), 16'd32);
    awr(1'b1, 8'h22); dwr(8'h05);
    chk("lfo_bank1", 16'(lfo), 16'hB);
    wait_idle();

    // FNUM high latch then low write on channel 4
    awr(1'b1, 8'hA5); dwr(8'h2C);
    wait_idle();
    awr(1'b1, 8'hA1); dwr(8'h9F);
    goto_ch(4);
    chk("ch4_fnum", 16'(fnum), 16'h49F);
    chk("ch4_block", 16'(block), 16'd5);
    for (int i = 0; i < 6; i++) begin
      tick(); idle();
      chk("fnum_other", 16'(fnum), (e_idx == 4) ? 16'h49F : 16'h0);
    end

    // Pan/AMS/PMS on channel 2, then a write while busy
    wait_idle();
    awr(1'b0, 8'hB6); dwr(8'hC5);
    dwr(8'h12);
    goto_ch(2);
    chk("ch2_lr", 16'(lr), 16'd3);
    chk("ch2_ams", 16'(ams), 16'd0);
    chk("ch2_pms", 16'(pms), 16'd5);
    wait_idle();
    idle();
`ifdef YM3438_WR_QUEUE_EN
    chk("q_reload", 16'(busy), 16'd1);
`else
    chk("q_reload", 16'(busy), 16'd0);
`endif
    goto_ch(2);
`ifdef YM3438_WR_QUEUE_EN
    chk("ch2_pms_2nd", 16'(pms), 16'd2);
    chk("ch2_lr_2nd", 16'(lr), 16'd0);
`else
    chk("ch2_pms_2nd", 16'(pms), 16'd5);
    chk("ch2_lr_2nd", 16'(lr), 16'd3);
`endif

    // Channel scan sequence and latency
    idle();
    seq = int'(ch_idx);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("scan_hold", 16'(ch_idx), 16'(seq));
      seq = (seq + 1) % 6;
      idle();
      chk("scan_step", 16'(ch_idx), 16'(seq));
    end

    // Reset while busy with a pending write
    wait_idle();
    awr(1'b0, 8'h21); dwr(8'h55);
    dwr(8'hAA);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst2_busy", 16'(busy), 16'd0);
    chk("rst2_reg21", 16'(reg_21), 16'd0);
    for (int i = 0; i < 40; i++) tick();
    idle();
    chk("rst2_nocommit", 16'(reg_21), 16'd0);
    chk("rst2_idle", 16'(busy), 16'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 5) begin
        step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 8'h00);
      end else if (r < 120) begin
        awr(1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)]);
      end else if (r < 260) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, 8'($urandom));
      end else if (r < 600) begin
        tick();
      end else begin
        idle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ym3438_reg_wr.md
Name: ym3438_reg_wr

Overview:
- CPU-side register write port for the OPN2 core; the writer end of the register interface that the LFO and phase blocks read.
- Accepts address/data bus writes and applies a busy handshake paced by slot ticks.
- Holds the global LFO registers and the per-channel FNUM/block/PMS/AMS/LR registers.
- Presents per-channel values in channel-scan order, so downstream blocks (LFO PM, phase generator) see fnum/pms for the current channel.

Parameters:
BUSY_TICKS, 32, number of slot_tick pulses that busy stays high after an accepted data write (legal range 1..255).

Ports:
MCLK  in  1  master clock; all state changes on its rising edge
IC  in  1  synchronous reset, active-high
slot_tick  in  1  one-MCLK pulse per channel slot; advances busy counter and channel scan
cpu_wr  in  1  one-MCLK write strobe
cpu_a0  in  1  0 = address write, 1 = data write
cpu_a1  in  1  bank select (0 = channels 0-2 plus globals, 1 = channels 3-5)
cpu_data  in  8  write data
busy  out  1  data-write busy flag
reg_21  out  8  global test register 0x21
lfo  out  4  register 0x22 bits [3:0]: bit 3 enable, bits [2:0] rate
ch_idx  out  3  channel currently presented, 0..5
fnum  out  11  F-number of ch_idx
block  out  3  block of ch_idx
pms  out  3  PMS of ch_idx
ams  out  2  AMS of ch_idx
lr  out  2  L/R enables of ch_idx

Behaviour:
- Reset (IC=1 at a clock edge) clears the following to 0:
  - addr_l, bank_l, fnum_hi_l[5:0]
  - all fnum/block/pms/ams arrays
  - reg_21, lfo, busy counter, ch_cnt
  - the queue (when the optional feature is built in)
- Reset sets every lr entry to 2'b11.
- Output values the cycle after reset: busy=0, ch_idx=0, fnum=0, block=0, pms=0, ams=0, lr=3, reg_21=0, lfo=0.
- Reset overrides a concurrent cpu_wr or slot_tick. Reset mid-busy drops the pending write.
- Address write (cpu_wr & ~cpu_a0): addr_l<=cpu_data and bank_l<=cpu_a1. Always accepted, including while busy.
- Data write (cpu_wr & cpu_a0):
  - While busy=0: commit to the register selected by (bank_l, addr_l). busy goes to 1 on the next cycle and the counter loads BUSY_TICKS.
  - While busy=1: dropped, unless the optional queue is built in.
  - An accepted write sets busy even when its address decodes to nothing.
- Decode, with c = addr_l[1:0] and ch = bank_l*3 + c:
  - 0x21 -> reg_21 = data. 0x22 -> lfo = data[3:0]. Both apply only when bank_l=0; bank 1 ignores them.
  - 0xA4..0xA6 -> fnum_hi_l = data[5:0]. This latch is shared by all channels and both banks.
  - 0xA0..0xA2 -> fnum[ch] = {fnum_hi_l[2:0], data} and block[ch] = fnum_hi_l[5:3]. fnum_hi_l is kept.
  - 0xB4..0xB6 -> lr[ch] = data[7:6], ams[ch] = data[5:4], pms[ch] = data[2:0].
  - c=3 (for example 0xA3, 0xA7, 0xB7) and all other addresses: no register effect.
- Busy counter:
  - Decrements on slot_tick while nonzero. busy = (counter != 0).
  - If a data write coincides with the tick that takes the counter 1->0, busy is still 1 in that cycle and the write is dropped (or queued).
- Channel scan:
  - ch_cnt increments on slot_tick and wraps 5->0. It runs independently of writes.
  - ch_idx and all per-channel outputs are registered, one MCLK after ch_cnt changes.
  - A commit to the channel currently presented appears on the outputs at most 2 MCLK after the data strobe.
- Width rules: all arrays are fixed width, with no arithmetic on the data. The busy counter is 8 bits.

Optional Feature:
- Macro: YM3438_WR_QUEUE_EN.
- With the macro defined:
  - A one-entry queue captures {bank_l, addr_l, data} for the first data write received while busy.
  - The queued entry commits in the cycle after busy falls and reloads the busy counter.
  - A second write while the queue is full is dropped.
  - An address write while queued does not alter the queued entry.
- Without the macro: data writes while busy are dropped.

Test Plan:
- Reset, then observe: busy=0, ch_idx=0, lfo=0, lr=3 for all six channels.
- Address write 0x22 (a1=0), data write 0x0B -> lfo=4'hB, busy=1 for exactly 32 slot_ticks. Repeat with a1=1 -> lfo unchanged.
- Write 0xA5=0x2C (a1=1), wait for busy=0, then write 0xA1=0x9F (a1=1) -> channel 4 presents fnum=0x49F, block=5. Other channels stay 0.
- Write 0xB6=0xC5 (a1=0) -> at ch_idx=2: lr=3, ams=0, pms=5. Issue a second data write while busy -> dropped without the macro; committed 1 cycle after busy falls with the macro.
- 20 slot_ticks with no writes -> ch_idx sequence 0,1,2,3,4,5,0,... with each step appearing 1 MCLK after its tick.
- Assert IC while busy=1 and the queue is full -> next cycle busy=0, queue empty, registers reset. The queued write never commits.
